// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing controller: shadow EX/MEM scoreboard, RAW hazard
// detection, latch stall/bubble/flush/freeze control and halt drain.
module decode_hazard_ctrl #(
  parameter bit          FORWARDING   = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [4:0] rsel1,
  input  logic [4:0] rsel2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic       Reg_write,
  input  logic [4:0] out_wsel,
  input  logic       Mem_Read,
  input  logic       Mem_Write,
  input  logic       halt,
  input  logic       branch_taken,
  output logic       stall_fd,
  output logic       bubble_de,
  output logic       flush_fd,
  output logic       freeze,
  output logic       halt_out
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] wsel;
    logic       rw;
    logic       load;
    logic       mem;
  } sb_entry_t;

  sb_entry_t      ex_q;
  sb_entry_t      dec_e;
  // The load flag only matters for the EX-stage load-use check, so MEM drops it.
  logic           mem_valid, mem_rw, mem_mem;
  logic [4:0]     mem_wsel;
  logic [1:0]     state_q;
  logic [CW-1:0]  cnt_q;

  logic raw_ex, raw_mem, hazard, halted, adv, halt_go;

  assign dec_e = {1'b1, out_wsel, Reg_write, Mem_Read, Mem_Read | Mem_Write};

  always_comb begin
    raw_ex  = ex_q.valid & ex_q.rw & (ex_q.wsel != 5'd0) &
              ((uses_rs1 & (rsel1 == ex_q.wsel)) | (uses_rs2 & (rsel2 == ex_q.wsel)));
    raw_mem = mem_valid & mem_rw & (mem_wsel != 5'd0) &
              ((uses_rs1 & (rsel1 == mem_wsel)) | (uses_rs2 & (rsel2 == mem_wsel)));
    hazard  = FORWARDING ? (raw_ex & ex_q.load) : (raw_ex | raw_mem);
  end

  assign freeze   = mem_valid & mem_mem & ~dhit;
  assign halted   = (state_q == HALTED);
  assign halt_out = halted;
  assign adv      = ihit & ~freeze & ~halted;
  assign halt_go  = (state_q == RUN) & halt & adv & ~branch_taken & ~hazard;

  always_comb begin
    stall_fd  = 1'b0;
    bubble_de = 1'b0;
    flush_fd  = 1'b0;
    if (!freeze) begin
      if (halted) begin
        stall_fd = 1'b1;
      end else if (state_q == DRAIN) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end else if (branch_taken) begin
        flush_fd  = 1'b1;
        bubble_de = 1'b1;
      end else if (hazard) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_q      <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_mem   <= 1'b0;
      mem_wsel  <= '0;
      state_q   <= RUN;
      cnt_q     <= '0;
    end else begin
      if (adv) begin
        mem_valid <= ex_q.valid;
        mem_rw    <= ex_q.rw;
        mem_mem   <= ex_q.mem;
        mem_wsel  <= ex_q.wsel;
        ex_q      <= bubble_de ? '0 : dec_e;
      end
      case (state_q)
        RUN: begin
          if (halt_go) begin
            if (DRAIN_CYCLES == 0) begin
              state_q <= HALTED;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= CW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          if (adv) begin
            if (cnt_q <= CW'(1)) begin
              state_q <= HALTED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: a forwarding and a non-forwarding instance
// share stimulus; an in-flight instruction model plus literal expectations check them.
module tb_decode_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, uses_rs1, uses_rs2, Reg_write, Mem_Read, Mem_Write, halt, branch_taken;
  logic [4:0] rsel1, rsel2, out_wsel;

  logic stall_f, bubble_f, flush_f, freeze_f, halt_f;
  logic stall_n, bubble_n, flush_n, freeze_n, halt_n;

  wire [4:0] vf = {stall_f, bubble_f, flush_f, freeze_f, halt_f};
  wire [4:0] vn = {stall_n, bubble_n, flush_n, freeze_n, halt_n};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  decode_hazard_ctrl #(.FORWARDING(1'b1), .DRAIN_CYCLES(2)) u_fwd (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .rsel1(rsel1), .rsel2(rsel2), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .Reg_write(Reg_write), .out_wsel(out_wsel), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .halt(halt), .branch_taken(branch_taken),
    .stall_fd(stall_f), .bubble_de(bubble_f), .flush_fd(flush_f),
    .freeze(freeze_f), .halt_out(halt_f));

  decode_hazard_ctrl #(.FORWARDING(1'b0), .DRAIN_CYCLES(2)) u_nofwd (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .rsel1(rsel1), .rsel2(rsel2), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .Reg_write(Reg_write), .out_wsel(out_wsel), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .halt(halt), .branch_taken(branch_taken),
    .stall_fd(stall_n), .bubble_de(bubble_n), .flush_fd(flush_n),
    .freeze(freeze_n), .halt_out(halt_n));

  // Model: per instance, the two instructions in flight (age 0 = just issued),
  // the number of advances still owed to a draining halt, and a stopped flag.
  typedef struct packed {
    bit       v;
    bit [4:0] w;
    bit       rw;
    bit       ld;
    bit       mm;
  } ins_t;

  ins_t pipe [2][2];
  int   drain_left [2];
  bit   stopped [2];

  always @(negedge CLK) begin
    logic [4:0] act, exp;
    bit fwd, frz, haz, reads, st, bb, fl, adv, draining;
    ins_t r;
    for (int k = 0; k < 2; k++) begin
      act = (k == 0) ? vf : vn;
      fwd = (k == 0);
      if (!nRST) begin
        for (int s = 0; s < 2; s++) pipe[k][s] = '0;
        drain_left[k] = -1;
        stopped[k]    = 1'b0;
        exp = 5'b00000;
      end else begin
        frz = pipe[k][1].v && pipe[k][1].mm && !dhit;
        haz = 1'b0;
        for (int s = 0; s < 2; s++) begin
          r = pipe[k][s];
          reads = r.v && r.rw && (r.w != 5'd0) &&
                  ((uses_rs1 && rsel1 == r.w) || (uses_rs2 && rsel2 == r.w));
          if (reads && (fwd ? (s == 0 && r.ld) : 1'b1)) haz = 1'b1;
        end
        draining = (drain_left[k] >= 0);
        st = 1'b0; bb = 1'b0; fl = 1'b0;
        if (!frz) begin
          if (stopped[k])        st = 1'b1;
          else if (draining)     begin st = 1'b1; bb = 1'b1; end
          else if (branch_taken) begin fl = 1'b1; bb = 1'b1; end
          else if (haz)          begin st = 1'b1; bb = 1'b1; end
        end
        exp = {st, bb, fl, frz, stopped[k]};
        adv = ihit && !frz && !stopped[k];
        if (adv) begin
          if (draining) begin
            drain_left[k] = drain_left[k] - 1;
            if (drain_left[k] == 0) begin
              stopped[k]    = 1'b1;
              drain_left[k] = -1;
            end
          end else if (halt && !branch_taken && !haz) begin
            drain_left[k] = 2;
          end
          pipe[k][1] = pipe[k][0];
          pipe[k][0] = bb ? ins_t'(0) : {1'b1, out_wsel, Reg_write, Mem_Read, Mem_Read | Mem_Write};
        end
      end
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_%s t=%0t got %b want %b (stall,bubble,flush,freeze,halt)",
                 fwd ? "fwd" : "nofwd", $time, act, exp);
      end
    end
  end

  task automatic lit(input string nm, input logic [4:0] ef, input logic [4:0] en);
    n_tests += 2;
    if (vf !== ef) begin
      n_fail++;
      $display("FAIL %s fwd got %b want %b", nm, vf, ef);
    end
    if (vn !== en) begin
      n_fail++;
      $display("FAIL %s nofwd got %b want %b", nm, vn, en);
    end
  endtask

  task automatic cyc_chk(input string nm, input logic [4:0] ef, input logic [4:0] en);
    @(negedge CLK); #1;
    lit(nm, ef, en);
    @(posedge CLK); #1;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic set_dec(input logic [4:0] wd, input logic rw, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic mr, input logic mw,
                         input logic h);
    out_wsel = wd; Reg_write = rw; rsel1 = s1; uses_rs1 = u1;
    rsel2 = s2; uses_rs2 = u2; Mem_Read = mr; Mem_Write = mw; halt = h;
  endtask

  task automatic nop();
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nops2();
    nop(); branch_taken = 1'b0; dhit = 1'b1; ihit = 1'b1;
    cyc(); cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b1; branch_taken = 1'b0;
    nop();
    @(negedge CLK); #1;
    lit("reset_state", 5'b00000, 5'b00000);
    @(posedge CLK); #1;
    nRST = 1'b1; ihit = 1'b1;

    // load-use: lw x5 then add x6,x5,x7
    set_dec(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc_chk("lu_issue", 5'b00000, 5'b00000);
    set_dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_chk("lu_stall1", 5'b11000, 5'b11000);
    cyc_chk("lu_stall2", 5'b00000, 5'b11000);
    nop();
    cyc_chk("lu_done", 5'b00000, 5'b00000);
    nops2();

    // same with x0 as destination
    set_dec(5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_dec(5'd6, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_chk("x0_nohaz", 5'b00000, 5'b00000);
    nops2();

    // ALU RAW: add x3 then sub x4,x3,x2
    set_dec(5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    set_dec(5'd4, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_chk("alu_raw1", 5'b00000, 5'b11000);
    cyc_chk("alu_raw2", 5'b00000, 5'b11000);
    cyc_chk("alu_raw3", 5'b00000, 5'b00000);
    nops2();

    // taken branch coinciding with load-use
    set_dec(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    set_dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b1;
    cyc_chk("br_flush", 5'b01100, 5'b01100);
    branch_taken = 1'b0;
    cyc_chk("br_ex_invalid", 5'b00000, 5'b11000);
    nops2();

    // data wait with branch pending: freeze wins for 3 cycles
    set_dec(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    nop();
    cyc();
    set_dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    dhit = 1'b0; branch_taken = 1'b1;
    cyc_chk("frz_br1", 5'b00010, 5'b00010);
    cyc_chk("frz_br2", 5'b00010, 5'b00010);
    cyc_chk("frz_br3", 5'b00010, 5'b00010);
    dhit = 1'b1;
    cyc_chk("frz_br_release", 5'b01100, 5'b01100);
    nops2();

    // data wait: the load stays in MEM while frozen
    set_dec(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    nop();
    cyc();
    set_dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    dhit = 1'b0;
    cyc_chk("frz1", 5'b00010, 5'b00010);
    cyc_chk("frz2", 5'b00010, 5'b00010);
    dhit = 1'b1;
    cyc_chk("frz_held_mem", 5'b00000, 5'b11000);
    nop();
    cyc_chk("frz_after", 5'b00000, 5'b00000);
    nops2();

    // halt drain, then sticky halt ignoring branch and ihit
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_chk("halt_leave", 5'b00000, 5'b00000);
    nop();
    cyc_chk("drain1", 5'b11000, 5'b11000);
    cyc_chk("drain2", 5'b11000, 5'b11000);
    cyc_chk("halted", 5'b10001, 5'b10001);
    branch_taken = 1'b1;
    cyc_chk("halted_br", 5'b10001, 5'b10001);
    branch_taken = 1'b0; ihit = 1'b0;
    cyc_chk("halted_noihit", 5'b10001, 5'b10001);
    nRST = 1'b0;
    cyc(); cyc();
    nRST = 1'b1; ihit = 1'b1;

    // halt drain stretched by a store waiting on dhit; branch ignored in drain
    set_dec(5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc_chk("sw_issue", 5'b00000, 5'b00000);
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_chk("halt_leave2", 5'b00000, 5'b00000);
    nop();
    dhit = 1'b0;
    cyc_chk("drain_frz1", 5'b00010, 5'b00010);
    cyc_chk("drain_frz2", 5'b00010, 5'b00010);
    dhit = 1'b1; branch_taken = 1'b1;
    cyc_chk("drain_br_ignored", 5'b11000, 5'b11000);
    branch_taken = 1'b0;
    cyc_chk("drain_last", 5'b11000, 5'b11000);
    cyc_chk("halted2", 5'b10001, 5'b10001);
    nRST = 1'b0;
    cyc(); cyc();
    nRST = 1'b1;

    // asynchronous reset in the middle of a drain
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_chk("halt_leave3", 5'b00000, 5'b00000);
    nop();
    @(negedge CLK); #1;
    lit("drain_before_rst", 5'b11000, 5'b11000);
    #2 nRST = 1'b0;
    #1;
    lit("async_rst", 5'b00000, 5'b00000);
    @(posedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    cyc_chk("run_after_rst", 5'b00000, 5'b00000);
    nops2();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
